// File: rtl/seq_divider_pkg.sv
// ----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the iterative restoring divider:
//   - div_state_e : FSM state encoding (IDLE, RUN, DONE)
//   - cnt_width() : width of the iteration counter for a given operand width
// ----------------------------------------------------------------------------
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // The counter must be able to hold every value 0..w.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// ----------------------------------------------------------------------------
// seq_divider_if
// Start/busy/done handshake bundle for the sequential divider.
//   start       : request a division (requester -> divider)
//   dividend    : numerator, sampled with start
//   divisor     : denominator, sampled with start
//   busy        : divider is iterating
//   done        : one-cycle pulse when results update
//   quotient    : registered quotient
//   remainder   : registered remainder
//   div_by_zero : last accepted operation had a zero divisor
// master = requester side, slave = divider side.
// ----------------------------------------------------------------------------
interface seq_divider_if #(
  parameter int WIDTH = 4
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_cla_subtractor.sv
// ----------------------------------------------------------------------------
// cla_subtractor
// Purely combinational N-bit subtractor: diff = a + ~b + 1, with every carry
// formed directly from generate/propagate terms (look-ahead, no ripple).
//   a, b : operands
//   diff : a - b modulo 2^N
//   cout : 1 when a >= b (no borrow)
// ----------------------------------------------------------------------------
module cla_subtractor #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         cout
);

  logic [N-1:0] bn_s;
  logic [N-1:0] g_s;
  logic [N-1:0] p_s;
  logic [N:0]   c_s;

  assign bn_s = ~b;
  assign g_s  = a & bn_s;
  assign p_s  = a ^ bn_s;

  // Look-ahead carries: c[i+1] = OR_j (g[j] & p[j+1..i]) | (cin & p[0..i]), cin = 1.
  always_comb begin
    logic c_acc;
    logic term;
    c_s    = {(N+1){1'b0}};
    c_s[0] = 1'b1;
    for (int i = 0; i < N; i++) begin
      c_acc = 1'b0;
      for (int j = 0; j <= i; j++) begin
        term = g_s[j];
        for (int k = j + 1; k <= i; k++) begin
          term = term & p_s[k];
        end
        c_acc = c_acc | term;
      end
      term = 1'b1;
      for (int k = 0; k <= i; k++) begin
        term = term & p_s[k];
      end
      c_acc      = c_acc | term;
      c_s[i + 1] = c_acc;
    end
  end

  assign diff = p_s ^ c_s[N-1:0];
  assign cout = c_s[N];

endmodule

// File: rtl/seq_divider.sv
// ----------------------------------------------------------------------------
// seq_divider
// Iterative unsigned restoring divider, one quotient bit per clock.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : seq_divider_if.slave (start/dividend/divisor in,
//           busy/done/quotient/remainder/div_by_zero out)
// A nonzero-divisor operation spends WIDTH cycles in RUN, then one cycle in
// DONE with done high. A zero divisor goes straight to DONE with quotient all
// ones and remainder equal to the dividend. All outputs are registered.
// ----------------------------------------------------------------------------
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  div_state_e       state_r, state_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [WIDTH-1:0] q_w_r, q_w_s;
  logic [WIDTH-1:0] d_w_r, d_w_s;
  logic [WIDTH:0]   r_w_r, r_w_s;
  logic [WIDTH-1:0] quotient_r, quotient_s;
  logic [WIDTH-1:0] remainder_r, remainder_s;
  logic             dbz_r, dbz_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;

  logic [WIDTH:0]   t_s;
  logic [WIDTH:0]   diff_s;
  logic             cout_s;

  // Trial value: partial remainder shifted left with the next dividend bit.
  assign t_s = {r_w_r[WIDTH-1:0], q_w_r[WIDTH-1]};

  cla_subtractor #(
    .N(WIDTH + 1)
  ) u_sub (
    .a   (t_s),
    .b   ({1'b0, d_w_r}),
    .diff(diff_s),
    .cout(cout_s)
  );

  // Next-state and next-register values for FSM, datapath and outputs.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    q_w_s       = q_w_r;
    d_w_s       = d_w_r;
    r_w_s       = r_w_r;
    quotient_s  = quotient_r;
    remainder_s = remainder_r;
    dbz_s       = dbz_r;

    case (state_r)
      IDLE: begin
        if (bus.start) begin
          if (bus.divisor != {WIDTH{1'b0}}) begin
            q_w_s   = bus.dividend;
            d_w_s   = bus.divisor;
            r_w_s   = {(WIDTH+1){1'b0}};
            cnt_s   = {CW{1'b0}};
            dbz_s   = 1'b0;
            state_s = RUN;
          end else begin
            quotient_s  = {WIDTH{1'b1}};
            remainder_s = bus.dividend;
            dbz_s       = 1'b1;
            state_s     = DONE;
          end
        end else begin
          state_s = IDLE;
        end
      end

      RUN: begin
        if (cout_s) begin
          r_w_s = diff_s;
          q_w_s = {q_w_r[WIDTH-2:0], 1'b1};
        end else begin
          r_w_s = t_s;
          q_w_s = {q_w_r[WIDTH-2:0], 1'b0};
        end
        cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        // Last iteration publishes the results this same edge.
        if (cnt_r == CW'(WIDTH - 1)) begin
          quotient_s  = q_w_s;
          remainder_s = r_w_s[WIDTH-1:0];
          state_s     = DONE;
        end else begin
          state_s = RUN;
        end
      end

      DONE: begin
        state_s = IDLE;
      end

      default: begin
        state_s = IDLE;
      end
    endcase

    // busy/done are registered images of the state being entered.
    busy_s = (state_s == RUN);
    done_s = (state_s == DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      q_w_r       <= {WIDTH{1'b0}};
      d_w_r       <= {WIDTH{1'b0}};
      r_w_r       <= {(WIDTH+1){1'b0}};
      quotient_r  <= {WIDTH{1'b0}};
      remainder_r <= {WIDTH{1'b0}};
      dbz_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      q_w_r       <= q_w_s;
      d_w_r       <= d_w_s;
      r_w_r       <= r_w_s;
      quotient_r  <= quotient_s;
      remainder_r <= remainder_s;
      dbz_r       <= dbz_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divider.sv
// ----------------------------------------------------------------------------
// tb_seq_divider
// Directed and exhaustive checks of seq_divider (WIDTH=4). A timeline model
// predicts every output on every cycle from plain / and % arithmetic; directed
// operations additionally check literal results, latency, busy length and
// issue period.
// ----------------------------------------------------------------------------
module tb_seq_divider;

  localparam int W = 4;

  logic clk;
  logic rst_n;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  int m_q = 0, m_r = 0, m_dbz = 0, m_busy = 0, m_done = 0;
  int m_active = 0, m_left = 0, p_q = 0, p_r = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_q = 0; m_r = 0; m_dbz = 0; m_busy = 0; m_done = 0;
        m_active = 0; m_left = 0;
      end else if (m_active == 0) begin
        m_done = 0;
        if (bus.start === 1'b1) begin
          m_active = 1;
          if (bus.divisor == 0) begin
            m_q = (1 << W) - 1; m_r = int'(bus.dividend); m_dbz = 1;
            m_done = 1; m_left = 1;
          end else begin
            p_q = int'(bus.dividend) / int'(bus.divisor);
            p_r = int'(bus.dividend) % int'(bus.divisor);
            m_dbz = 0; m_busy = 1; m_left = W + 1;
          end
        end
      end else begin
        m_done = 0;
        m_left--;
        if (m_busy == 1 && m_left == 1) begin
          m_busy = 0; m_done = 1; m_q = p_q; m_r = p_r;
        end
        if (m_left == 0) m_active = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("cyc_busy", int'(bus.busy), m_busy);
      chk("cyc_done", int'(bus.done), m_done);
      chk("cyc_quot", int'(bus.quotient), m_q);
      chk("cyc_rem",  int'(bus.remainder), m_r);
      chk("cyc_dbz",  int'(bus.div_by_zero), m_dbz);
    end
  end

  // Issue one operation from IDLE and wait until the divider is idle again.
  task automatic run_op(input int dd, input int dv, input int eq, input int er,
                        input int edbz, input int elat, input int eper);
    int lat, nbusy;
    bus.start = 1'b1; bus.dividend = W'(dd); bus.divisor = W'(dv);
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1; nbusy = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      if (bus.busy === 1'b1) nbusy++;
      @(negedge clk);
      lat++;
    end
    if (lat >= 20) chk("timeout_done", lat, elat);
    else begin
      chk("op_latency", lat, elat);
      chk("op_busy_cycles", nbusy, (dv == 0) ? 0 : W);
      chk("op_quot", int'(bus.quotient), eq);
      chk("op_rem", int'(bus.remainder), er);
      chk("op_dbz", int'(bus.div_by_zero), edbz);
    end
    @(negedge clk);
    chk("op_no_double_done", int'(bus.done), 0);
    chk("op_period", lat + 1, eper);
  endtask

  initial begin
    rst_n = 1'b0; bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_quot", int'(bus.quotient), 0);
    chk("rst_rem",  int'(bus.remainder), 0);
    chk("rst_dbz",  int'(bus.div_by_zero), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Hand-computed directed vectors.
    run_op(13, 4, 3, 1, 0, 5, 6);
    run_op(15, 1, 15, 0, 0, 5, 6);
    run_op(3, 7, 0, 3, 0, 5, 6);
    run_op(9, 0, 15, 9, 1, 1, 2);

    // Starts during RUN and DONE are ignored.
    bus.start = 1'b1; bus.dividend = 4'd13; bus.divisor = 4'd4;
    @(negedge clk);
    bus.dividend = 4'd15; bus.divisor = 4'd3;   // start still high in RUN
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 20 && bus.done !== 1'b1; i++) @(negedge clk);
    chk("ign_done_seen", int'(bus.done), 1);
    bus.start = 1'b1;                            // start high in DONE
    @(negedge clk);
    bus.start = 1'b0;
    chk("ign_quot", int'(bus.quotient), 3);
    chk("ign_rem",  int'(bus.remainder), 1);
    chk("ign_busy", int'(bus.busy), 0);
    run_op(15, 3, 5, 0, 0, 5, 6);

    // Reset in the middle of RUN.
    bus.start = 1'b1; bus.dividend = 4'd14; bus.divisor = 4'd3;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_done", int'(bus.done), 0);
    chk("midrst_quot", int'(bus.quotient), 0);
    chk("midrst_rem",  int'(bus.remainder), 0);
    chk("midrst_dbz",  int'(bus.div_by_zero), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_no_done_quot", int'(bus.quotient), 0);
    run_op(14, 3, 4, 2, 0, 5, 6);

    // Exhaustive back-to-back sweep.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) run_op(a, b, 15, a, 1, 1, 2);
        else        run_op(a, b, a / b, a % b, 0, 5, 6);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
